// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave front end.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Command field carried in frame bits [9:8].
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus the rx/tx handshake toward the downstream memory.
interface spi_slave_if;
  import spi_pkg::*;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );

endinterface

// File: rtl/spi_tx_shifter.sv
// Parallel-in serial-out reply shifter; MISO is a register and is 0 while idle.
module spi_tx_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              miso,
  output logic              busy
);

  logic [DATA_W-1:0] sreg;
  logic [2:0]        cnt;

  // The MSB goes straight to MISO on load, so cnt tracks the bits still queued in sreg.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sreg <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      miso <= 1'b0;
    end else if (load) begin
      miso <= din[DATA_W-1];
      sreg <= {din[DATA_W-2:0], 1'b0};
      cnt  <= 3'(DATA_W - 1);
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        miso <= sreg[DATA_W-1];
        sreg <= {sreg[DATA_W-2:0], 1'b0};
        cnt  <= cnt - 1'b1;
      end else begin
        miso <= 1'b0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: frames 10-bit commands from MOSI and serialises the memory read reply on MISO.
module spi_slave
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-2:0] shreg;
  logic [FRAME_W-1:0] rx_data_q;
  logic               rx_valid_q;
  logic               rd_addr_done;
  logic               await_rd;
  logic               shifting;
  logic               frame_done;
  logic               tx_load;
  logic               miso;
  logic               tx_busy;

  assign shifting   = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  // An SS_n rise on the tenth-bit edge still counts as an abort.
  assign frame_done = shifting && !bus.SS_n && (bit_cnt == CNT_W'(FRAME_W - 1));
  assign tx_load    = await_rd && bus.tx_valid && !bus.SS_n;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (bus.SS_n)          state_nxt = IDLE;
        else if (!bus.MOSI)    state_nxt = WRITE;
        else if (rd_addr_done) state_nxt = READ_DATA;
        else                   state_nxt = READ_ADD;
      end
      default: if (bus.SS_n) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_done <= 1'b0;
      await_rd     <= 1'b0;
    end else begin
      rx_valid_q <= frame_done;
      if (frame_done) rx_data_q <= {shreg, bus.MOSI};

      // Once the frame is full the counter parks at FRAME_W and MOSI is ignored.
      if (bus.SS_n || state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == CHK_CMD || (shifting && bit_cnt != CNT_W'(FRAME_W))) begin
        shreg   <= {shreg[FRAME_W-3:0], bus.MOSI};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (frame_done && state == READ_ADD)       rd_addr_done <= 1'b1;
      else if (frame_done && state == READ_DATA) rd_addr_done <= 1'b0;

      // Exactly one reply is accepted per READ_DATA frame.
      if (bus.SS_n)                               await_rd <= 1'b0;
      else if (frame_done && state == READ_DATA)  await_rd <= 1'b1;
      else if (tx_load)                           await_rd <= 1'b0;
    end
  end

  spi_tx_shifter u_tx (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.SS_n),
    .load (tx_load),
    .din  (bus.tx_data),
    .miso (miso),
    .busy (tx_busy)
  );

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  a_rx_pulse:  assert property (@(posedge clk) disable iff (rst) rx_valid_q |=> !rx_valid_q);
  a_miso_idle: assert property (@(posedge clk) disable iff (rst) !tx_busy |-> !miso);
  a_one_reply: assert property (@(posedge clk) disable iff (rst) !(await_rd && tx_busy));

endmodule

// File: tb/tb_spi_slave.sv
// Randomised frame-level bench for spi_slave against a transaction model of the protocol.
module tb_spi_slave;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  spi_slave_if bus();

  spi_slave dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  // Model state: a read address is pending, and the last frame the slave reported.
  bit                 rd_pend = 1'b0;
  logic [FRAME_W-1:0] last_rx = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_vld"},  32'(bus.rx_valid), 32'd0);
    chk({tag, "_miso"}, 32'(bus.MISO),     32'd0);
    chk({tag, "_data"}, 32'(bus.rx_data),  32'(last_rx));
  endtask

  // mode: 0 full reply, 1 SS_n abort after bit k, 2 abort on the tx_valid edge, 3 reset after bit k
  task automatic reply(input logic [DATA_W-1:0] d, input int mode, input int k);
    int w;
    w = $urandom_range(1, 3);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < w; i++) begin
      bus.MOSI = 1'($urandom);
      tick();
      quiet("wait");
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    if (mode == 2) begin
      bus.SS_n = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      quiet("abort_tx");
      return;
    end
    tick();
    bus.tx_valid = 1'b0;
    for (int b = 0; b < DATA_W; b++) begin
      chk("miso_bit", 32'(bus.MISO), 32'(d[DATA_W-1-b]));
      chk("tx_vld",   32'(bus.rx_valid), 32'd0);
      if (mode == 1 && b == k) begin
        bus.SS_n = 1'b1;
        tick();
        quiet("abort_mid");
        return;
      end
      if (mode == 3 && b == k) begin
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        rd_pend = 1'b0;
        last_rx = '0;
        quiet("rst_mid");
        return;
      end
      bus.tx_valid = 1'($urandom_range(0, 2) == 0);
      bus.tx_data  = 8'($urandom);
      bus.MOSI     = 1'($urandom);
      tick();
      bus.tx_valid = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      quiet("tail");
      tick();
    end
    quiet("tail");
  endtask

  // abort_at: bits shifted before SS_n rises (-1 for a complete frame).
  task automatic run_frame(input logic [FRAME_W-1:0] f, input int abort_at,
                           input logic [DATA_W-1:0] d, input int mode, input int k);
    int n_post;
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom);
    tick();
    quiet("sel");
    for (int n = 0; n < FRAME_W; n++) begin
      if (n == abort_at) begin
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'($urandom);
        bus.tx_data  = 8'($urandom);
        tick();
        bus.tx_valid = 1'b0;
        quiet("abort");
        return;
      end
      bus.MOSI     = f[FRAME_W-1-n];
      bus.tx_valid = 1'((n < FRAME_W - 1) && ($urandom_range(0, 3) == 0));
      bus.tx_data  = 8'($urandom);
      tick();
      bus.tx_valid = 1'b0;
      if (n < FRAME_W - 1) quiet("bit");
    end
    chk("rx_valid", 32'(bus.rx_valid), 32'd1);
    chk("rx_data",  32'(bus.rx_data),  32'(f));
    last_rx = f;
    if (f[FRAME_W-1] && rd_pend) begin
      rd_pend = 1'b0;
      reply(d, mode, k);
    end else begin
      if (f[FRAME_W-1]) rd_pend = 1'b1;
      n_post = $urandom_range(1, 4);
      for (int i = 0; i < n_post; i++) begin
        bus.MOSI     = 1'($urandom);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        tick();
        quiet("post");
      end
    end
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    tick();
    quiet("desel");
  endtask

  initial begin
    rst          = 1'b1;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      quiet("reset");
    end
    rst = 1'b0;
    tick();
    quiet("post_reset");

    run_frame(10'h005, -1, 8'hFF, 0, 0);
    run_frame(10'h1AA, -1, 8'hFF, 0, 0);
    run_frame(10'h205, -1, 8'h00, 0, 0);
    run_frame(10'h300, -1, 8'hA5, 0, 0);
    run_frame(10'h0F0,  6, 8'h00, 0, 0);
    run_frame(10'h003, -1, 8'hFF, 0, 0);
    run_frame(10'h205, -1, 8'h00, 0, 0);
    run_frame(10'h3C3, -1, 8'h5A, 3, 3);
    run_frame(10'h2FF, -1, 8'hFF, 0, 0);
    run_frame(10'h300, -1, 8'h81, 0, 0);
    run_frame(10'h2AA, -1, 8'h00, 0, 0);
    run_frame(10'h3AA, -1, 8'hFF, 2, 0);
    run_frame(10'h211,  9, 8'h00, 0, 0);
    run_frame(10'h211, -1, 8'h00, 0, 0);
    run_frame(10'h3FF,  0, 8'h00, 0, 0);
    run_frame(10'h3FF, -1, 8'hC3, 1, 4);

    for (int it = 0; it < 80; it++) begin
      logic [FRAME_W-1:0] f;
      int ab, md;
      f  = 10'($urandom);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      md = int'($urandom_range(0, 7));
      if (md > 3) md = 0;
      run_frame(f, ab, 8'($urandom), md, int'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
